// File: rtl/msg_rx_pkg.sv
// Shared types and header-field constants for the message-receive deframer.
package msg_rx_pkg;

  typedef enum logic [1:0] {HDR, PAY, HOLD, DRAIN} rx_state_t;

  localparam int unsigned HDR_ID_LSB  = 16;
  localparam int unsigned HDR_LEN_MSB = 15;

  typedef struct packed {
    logic [15:0] id;
    logic [15:0] len;
  } msg_hdr_t;

endpackage

// File: rtl/msg_rx_deframer_if.sv
// PipeInLast input stream plus the assembled-message output bundle.
interface msg_rx_deframer_if #(
  parameter int unsigned MAX_WORDS = 8,
  parameter int unsigned ID_WIDTH  = 16
);
  logic                      enq__ENA;
  logic [31:0]               enq_v;
  logic                      enq_last;
  logic                      enq__RDY;
  logic                      msg__ENA;
  logic [ID_WIDTH-1:0]       msg_id;
  logic [7:0]                msg_len;
  logic [MAX_WORDS*32-1:0]   msg_data;
  logic                      msg__RDY;
  logic [15:0]               err_count;

  modport master (
    output enq__ENA, enq_v, enq_last, msg__RDY,
    input  enq__RDY, msg__ENA, msg_id, msg_len, msg_data, err_count
  );

  modport slave (
    input  enq__ENA, enq_v, enq_last, msg__RDY,
    output enq__RDY, msg__ENA, msg_id, msg_len, msg_data, err_count
  );
endinterface

// File: rtl/msg_rx_payload_buf.sv
// Word-indexed payload register array; cleared on each accepted header.
module msg_rx_payload_buf #(
  parameter int unsigned MAX_WORDS = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clr_i,
  input  logic                    we_i,
  input  logic [7:0]              idx_i,
  input  logic [31:0]             wdata_i,
  output logic [MAX_WORDS*32-1:0] data_o
);

  logic [MAX_WORDS-1:0][31:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (clr_i) begin
      data_d = '0;
    end else if (we_i) begin
      for (int unsigned i = 0; i < MAX_WORDS; i++) begin
        if (idx_i == 8'(i)) data_d[i] = wdata_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) data_q <= '0;
    else       data_q <= data_d;
  end

  assign data_o = data_q;

endmodule

// File: rtl/msg_rx_deframer.sv
// Deframes header+payload word streams into whole messages, resyncing on last.
// Define MSGRX_ERRCNT_EN to implement the saturating framing-error counter.
module msg_rx_deframer
  import msg_rx_pkg::*;
#(
  parameter int unsigned MAX_WORDS = 8,
  parameter int unsigned ID_WIDTH  = 16
) (
  input logic              CLK,
  input logic              RST,
  msg_rx_deframer_if.slave bus
);

  rx_state_t           state_q, state_d;
  logic                rdy_q, rdy_d;
  logic                ena_q, ena_d;
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic [7:0]          len_q, len_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                xfer, last, err_evt, buf_clr, buf_we;
  msg_hdr_t            hdr;

  assign xfer = bus.enq__ENA & rdy_q;
  assign last = bus.enq_last;
  assign hdr  = '{id: bus.enq_v[31:HDR_ID_LSB], len: bus.enq_v[HDR_LEN_MSB:0]};

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    err_evt = 1'b0;
    buf_clr = 1'b0;
    buf_we  = 1'b0;
    unique case (state_q)
      HDR: begin
        if (xfer) begin
          id_d    = hdr.id[ID_WIDTH-1:0];
          len_d   = hdr.len[7:0];
          cnt_d   = '0;
          buf_clr = 1'b1;
          if (hdr.len > 16'(MAX_WORDS)) begin
            err_evt = 1'b1;
            state_d = last ? HDR : DRAIN;
          end else if (hdr.len == '0) begin
            err_evt = ~last;
            state_d = last ? HOLD : DRAIN;
          end else if (last) begin
            err_evt = 1'b1;
          end else begin
            state_d = PAY;
          end
        end
      end
      PAY: begin
        if (xfer) begin
          buf_we = 1'b1;
          cnt_d  = cnt_q + 8'd1;
          // A frame that overruns len is dropped and drained to its last word.
          if ((9'(cnt_q) + 9'd1) == 9'(len_q)) begin
            err_evt = ~last;
            state_d = last ? HOLD : DRAIN;
          end else if (last) begin
            err_evt = 1'b1;
            state_d = HDR;
          end
        end
      end
      HOLD: begin
        if (ena_q && bus.msg__RDY) state_d = HDR;
      end
      DRAIN: begin
        if (xfer && last) state_d = HDR;
      end
      default: state_d = HDR;
    endcase
    rdy_d = (state_d != HOLD);
    ena_d = (state_d == HOLD);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= HDR;
      rdy_q   <= 1'b1;
      ena_q   <= 1'b0;
      id_q    <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      ena_q   <= ena_d;
      id_q    <= id_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  msg_rx_payload_buf #(
    .MAX_WORDS(MAX_WORDS)
  ) u_buf (
    .clk_i   (CLK),
    .rst_i   (RST),
    .clr_i   (buf_clr),
    .we_i    (buf_we),
    .idx_i   (cnt_q),
    .wdata_i (bus.enq_v),
    .data_o  (bus.msg_data)
  );

`ifdef MSGRX_ERRCNT_EN
  logic [15:0] err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (err_evt && (err_q != 16'hFFFF)) err_d = err_q + 16'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) err_q <= '0;
    else     err_q <= err_d;
  end

  assign bus.err_count = err_q;
`else
  logic unused_err_evt;
  assign unused_err_evt = err_evt;
  assign bus.err_count  = '0;
`endif

  assign bus.enq__RDY = rdy_q;
  assign bus.msg__ENA = ena_q;
  assign bus.msg_id   = id_q;
  assign bus.msg_len  = len_q;

endmodule

// File: tb/tb_msg_rx_deframer.sv
// Directed plus random frames checked against a frame-level model of the deframer.
module tb_msg_rx_deframer;
  localparam int unsigned MAXW = 8;
  localparam int unsigned DW   = MAXW * 32;

  logic CLK = 1'b0;
  logic RST;
  int   checks = 0;
  int   errors = 0;
  int   exp_err = 0;
  logic [31:0] fq[$];

  msg_rx_deframer_if #(.MAX_WORDS(MAXW), .ID_WIDTH(16)) bus ();

  msg_rx_deframer #(.MAX_WORDS(MAXW), .ID_WIDTH(16)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_errc();
`ifdef MSGRX_ERRCNT_EN
    return 16'(exp_err);
`else
    return 16'd0;
`endif
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Entered and left at posedge+1; returns just after the accepting edge.
  task automatic send_word(input logic [31:0] v, input logic lst);
    int n = 0;
    bus.enq__ENA = 1'b1;
    bus.enq_v    = v;
    bus.enq_last = lst;
    @(negedge CLK);
    while (!bus.enq__RDY && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (n == 20) chk("enq_rdy_timeout", DW'(bus.enq__RDY), DW'(1));
    tick();
    bus.enq__ENA = 1'b0;
  endtask

  task automatic check_msg(input logic [15:0] id, input logic [7:0] len,
                           input logic [DW-1:0] data, input int stall);
    chk("msg_ena_latency", DW'(bus.msg__ENA), DW'(1));
    chk("msg_id", DW'(bus.msg_id), DW'(id));
    chk("msg_len", DW'(bus.msg_len), DW'(len));
    chk("msg_data", bus.msg_data, data);
    chk("msg_err_count", DW'(bus.err_count), DW'(exp_errc()));
    chk("hold_rdy_low", DW'(bus.enq__RDY), DW'(0));
    for (int i = 0; i < stall; i++) begin
      tick();
      chk("stall_ena", DW'(bus.msg__ENA), DW'(1));
      chk("stall_data", bus.msg_data, data);
      chk("stall_rdy", DW'(bus.enq__RDY), DW'(0));
    end
    bus.msg__RDY = 1'b1;
    tick();
    bus.msg__RDY = 1'b0;
    chk("post_hs_ena", DW'(bus.msg__ENA), DW'(0));
    chk("post_hs_rdy", DW'(bus.enq__RDY), DW'(1));
  endtask

  // A frame is everything up to its last word; it yields one message or one error.
  task automatic run_frame(input int gap_max, input int stall);
    logic [15:0]   hl;
    bit            ok;
    logic [DW-1:0] ed;
    for (int i = 0; i < fq.size(); i++) begin
      repeat ($urandom_range(gap_max, 0)) tick();
      send_word(fq[i], (i == fq.size() - 1));
    end
    hl = fq[0][15:0];
    ok = (hl <= 16'(MAXW)) && (fq.size() == int'(hl) + 1);
    if (!ok) begin
      exp_err++;
      chk("bad_no_msg", DW'(bus.msg__ENA), DW'(0));
      chk("bad_rdy", DW'(bus.enq__RDY), DW'(1));
      chk("bad_err_count", DW'(bus.err_count), DW'(exp_errc()));
    end else begin
      ed = '0;
      for (int i = 1; i < fq.size(); i++) ed[(i-1)*32 +: 32] = fq[i];
      check_msg(fq[0][31:16], hl[7:0], ed, stall);
    end
  endtask

  task automatic mk(input logic [15:0] id, input logic [15:0] len, input int n,
                    input logic [31:0] base, input bit rnd);
    fq = {};
    fq.push_back({id, len});
    for (int i = 0; i < n; i++) fq.push_back(rnd ? $urandom : base + 32'(i));
  endtask

  initial begin
    int k, len, n;
    RST          = 1'b1;
    bus.enq__ENA = 1'b0;
    bus.enq_v    = '0;
    bus.enq_last = 1'b0;
    bus.msg__RDY = 1'b0;
    repeat (2) tick();
    RST = 1'b0;
    chk("rst_rdy", DW'(bus.enq__RDY), DW'(1));
    chk("rst_ena", DW'(bus.msg__ENA), DW'(0));
    chk("rst_id", DW'(bus.msg_id), DW'(0));
    chk("rst_len", DW'(bus.msg_len), DW'(0));
    chk("rst_data", bus.msg_data, DW'(0));
    chk("rst_err", DW'(bus.err_count), DW'(0));

    mk(16'd3, 16'd2, 2, 32'hA, 1'b0);
    run_frame(0, 0);

    // Backpressure: next header is offered while the message is stalled.
    mk(16'd3, 16'd2, 2, 32'hA, 1'b0);
    send_word(fq[0], 1'b0);
    send_word(fq[1], 1'b0);
    send_word(fq[2], 1'b1);
    bus.enq__ENA = 1'b1;
    bus.enq_v    = 32'h0005_0001;
    bus.enq_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("bp_rdy", DW'(bus.enq__RDY), DW'(0));
      chk("bp_ena", DW'(bus.msg__ENA), DW'(1));
      chk("bp_data", bus.msg_data, DW'({32'hB, 32'hA}));
      chk("bp_id", DW'(bus.msg_id), DW'(3));
    end
    bus.msg__RDY = 1'b1;
    tick();
    bus.msg__RDY = 1'b0;
    chk("bp_hs_ena", DW'(bus.msg__ENA), DW'(0));
    chk("bp_hs_rdy", DW'(bus.enq__RDY), DW'(1));
    chk("bp_hs_data", bus.msg_data, DW'({32'hB, 32'hA}));
    tick();
    bus.enq__ENA = 1'b0;
    chk("bp_hdr_taken_data", bus.msg_data, DW'(0));
    send_word(32'h55, 1'b1);
    check_msg(16'd5, 8'd1, DW'(32'h55), 0);

    mk(16'd7, 16'd0, 0, 32'h0, 1'b0);
    run_frame(0, 1);
    mk(16'd1, 16'd3, 2, 32'h1, 1'b0);
    run_frame(0, 0);
    mk(16'd2, 16'd9, 9, 32'h100, 1'b0);
    run_frame(0, 0);
    mk(16'd4, 16'd1, 2, 32'h200, 1'b0);
    run_frame(0, 0);
    mk(16'd6, 16'd2, 0, 32'h0, 1'b0);
    run_frame(0, 0);
    mk(16'd8, 16'd1, 1, 32'hCAFE, 1'b0);
    run_frame(1, 2);

    // Reset in the middle of a payload.
    send_word(32'h0009_0004, 1'b0);
    send_word(32'h1, 1'b0);
    send_word(32'h2, 1'b0);
    RST = 1'b1;
    tick();
    RST     = 1'b0;
    exp_err = 0;
    chk("midrst_rdy", DW'(bus.enq__RDY), DW'(1));
    chk("midrst_ena", DW'(bus.msg__ENA), DW'(0));
    chk("midrst_data", bus.msg_data, DW'(0));
    chk("midrst_err", DW'(bus.err_count), DW'(0));
    mk(16'd12, 16'd3, 3, 32'h30, 1'b0);
    run_frame(0, 0);

    for (int f = 0; f < 200; f++) begin
      k = int'($urandom_range(5, 0));
      if (k <= 2) begin
        len = int'($urandom_range(MAXW, 0));
        n   = len;
      end else if (k == 3) begin
        len = int'($urandom_range(MAXW, 1));
        n   = int'($urandom_range(len - 1, 0));
      end else if (k == 4) begin
        len = int'($urandom_range(MAXW, 0));
        n   = len + int'($urandom_range(3, 1));
      end else begin
        len = int'($urandom_range(300, MAXW + 1));
        n   = int'($urandom_range(10, 0));
      end
      mk(16'($urandom), 16'(len), n, 32'h0, 1'b1);
      run_frame(2, int'($urandom_range(3, 0)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/msg_rx_deframer.md
Name: msg_rx_deframer

Overview:
- Downstream neighbour of the simulation message-receive source.
- Server side of the PipeInLast stream: 32-bit words with a last flag, enq__ENA/enq__RDY handshake.
- Parses a header word, collects payload words into a wide buffer, presents one complete message to the method-dispatch stage.
- Detects framing errors and resynchronises on the next last-flagged word.

Parameters:
- MAX_WORDS, 8: payload capacity in 32-bit words (1..255).
- ID_WIDTH, 16: method-id width taken from header bits [31:16].

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  synchronous, active-high reset.
- enq__ENA  in  1  input word valid; a transfer occurs when enq__ENA and enq__RDY are both high.
- enq$v  in  32  input word.
- enq$last  in  1  final word of the frame.
- enq__RDY  out  1  deframer can accept a word.
- msg__ENA  out  1  complete message valid.
- msg$id  out  ID_WIDTH  method id.
- msg$len  out  8  payload word count.
- msg$data  out  MAX_WORDS*32  payload; word i at [i*32 +: 32].
- msg__RDY  in  1  consumer accepts; message handshake when msg__ENA and msg__RDY are both high.
- err_count  out  16  framing-error count (see Optional Feature).

Behaviour:
Reset: all registers take these values on the first CLK edge with RST high, regardless of the current state.
- State = HDR.
- enq__RDY=1, msg__ENA=0, msg$id=0, msg$len=0, msg$data=0, err_count=0.

States: HDR, PAY, HOLD, DRAIN.
- enq__RDY = 1 in HDR, PAY and DRAIN; 0 in HOLD.
- msg__ENA = 1 only in HOLD.

HDR, on word transfer:
- Latch id = v[31:16], len = v[15:0].
- Clear msg$data to 0.
- Clear the word counter cnt.
- Transitions, in this order:
  - len > MAX_WORDS: count error; go to DRAIN if last=0, stay in HDR if last=1.
  - len==0 and last=1: go to HOLD.
  - len==0 and last=0: count error, go to DRAIN.
  - len>0 and last=1: count error, stay in HDR.
  - Otherwise: go to PAY.
- msg$len = len[7:0]; safe because len ≤ MAX_WORDS ≤ 255 on the PAY/HOLD paths.

PAY, on word transfer:
- Write v to word cnt of msg$data; cnt increments.
- Transitions:
  - cnt+1==len and last=1: go to HOLD.
  - cnt+1==len and last=0: count error, go to DRAIN. Payload is discarded and msg__ENA is never raised for it.
  - cnt+1<len and last=1: count error (short frame), go to HDR.
  - Otherwise: stay in PAY.

DRAIN:
- Accepts and discards words.
- Goes to HDR on the transfer with last=1.

HOLD:
- Outputs are stable while msg__ENA=1 and msg__RDY=0.
- On the message handshake, go to HDR the next cycle.
- No word is accepted in the handshake cycle (enq__RDY is still 0 then).

Timing:
- Latency: msg__ENA rises on the cycle after the final payload word transfer, or after the header for len==0.
- Throughput: one word per cycle; one idle input cycle per message at the HOLD handshake.

enq__ENA while enq__RDY=0: ignored; the input words are not consumed.

err_count:
- +1 per error event.
- Saturates at 0xFFFF.

Optional Feature:
- Macro: MSGRX_ERRCNT_EN.
- Defined: err_count is implemented as above.
- Undefined: err_count is tied to 0, no counter flops; framing-error recovery is unchanged.

Decomposition:
- Package msg_rx_pkg holds:
  - state enum rx_state_t {HDR, PAY, HOLD, DRAIN}
  - constants HDR_ID_LSB=16, HDR_LEN_MSB=15
  - typedef msg_hdr_t (struct: id[15:0], len[15:0])
- One natural sub-module: msg_rx_payload_buf, the word-indexed write/clear register array driven by cnt.
- FSM and error counter stay in the top module.

Test Plan:
- Reset mid-message: assert RST during PAY after 2 of 4 words -> next cycle state HDR, msg$data=0, enq__RDY=1; a following clean frame is delivered correctly.
- Normal frame: header 0x0003_0002, words 0xA, 0xB(last), msg__RDY=1 -> msg__ENA high one cycle after 0xB, msg$id=3, msg$len=2, data word0=0xA, word1=0xB, err_count=0.
- Backpressure: same frame with msg__RDY=0 for 5 cycles -> enq__RDY=0 and outputs stable for 5 cycles; the next header, offered during the stall, is accepted only after the handshake.
- Zero-length: header 0x0007_0000 with last=1 -> msg__ENA next cycle, msg$id=7, msg$len=0, msg$data=0.
- Short frame: header len=3, words 1, 2(last) -> no msg__ENA, err_count=1, next frame parsed normally.
- Oversize/long frames:
  - Header len=9 (MAX_WORDS=8) followed by 9 words, last on the ninth -> DRAIN, err_count=1, no message.
  - Header len=1, then 2 words with last on the second -> err_count=2; back in HDR after the last word.
